// File: rtl/ttl_pkg.sv
// Shared TTL quad-gate tester definitions: FSM states, pin bit positions,
// vector width and the expected-output function for the 7402 NOR quad.
package ttl_pkg;

  localparam int unsigned VEC_W = 8;
  localparam int unsigned OUT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POWER,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } tester_state_e;

  // Bit positions inside the packed input vector {P12,P11,P9,P8,P6,P5,P3,P2}
  localparam int unsigned PIN_P2  = 0;
  localparam int unsigned PIN_P3  = 1;
  localparam int unsigned PIN_P5  = 2;
  localparam int unsigned PIN_P6  = 3;
  localparam int unsigned PIN_P8  = 4;
  localparam int unsigned PIN_P9  = 5;
  localparam int unsigned PIN_P11 = 6;
  localparam int unsigned PIN_P12 = 7;

  // Bit positions inside the packed output vector {P13,P10,P4,P1}
  localparam int unsigned PIN_P1  = 0;
  localparam int unsigned PIN_P4  = 1;
  localparam int unsigned PIN_P10 = 2;
  localparam int unsigned PIN_P13 = 3;

  function automatic logic [OUT_W-1:0] NOR_QUAD_EXPECT(input logic [VEC_W-1:0] v);
    logic [OUT_W-1:0] r;
    r          = '0;
    r[PIN_P1]  = ~(v[PIN_P2]  | v[PIN_P3]);
    r[PIN_P4]  = ~(v[PIN_P5]  | v[PIN_P6]);
    r[PIN_P10] = ~(v[PIN_P8]  | v[PIN_P9]);
    r[PIN_P13] = ~(v[PIN_P11] | v[PIN_P12]);
    return r;
  endfunction

endpackage

// File: rtl/sn7402_tester_if.sv
// Pin-level connection between the tester and a 14-pin quad-gate device model.
interface sn7402_tester_if;
  import ttl_pkg::*;

  logic [VEC_W-1:0] dut_in;
  logic             dut_vcc;
  logic             dut_gnd;
  logic [OUT_W-1:0] dut_out;

  modport master (output dut_in, output dut_vcc, output dut_gnd, input dut_out);
  modport slave  (input dut_in, input dut_vcc, input dut_gnd, output dut_out);

endinterface

// File: rtl/sn7402_tester_nor4_expect.sv
// Combinational expected-output generator for a quad 2-input NOR device.
module nor4_expect
  import ttl_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic [OUT_W-1:0] exp_o
);

  assign exp_o = NOR_QUAD_EXPECT(vec_i);

endmodule

// File: rtl/sn7402_tester.sv
// Exhaustive 256-vector driver/checker for the SN7402 pin model.
// Define SN7402_TESTER_STOP_ON_FAIL_EN to end a run at the first mismatch.
module sn7402_tester
  import ttl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  sn7402_tester_if.master      pins,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [8:0]           err_count,
  output logic                 fail_valid,
  output logic [VEC_W-1:0]     fail_vec
);

`ifdef SN7402_TESTER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  // Power-up always takes at least one cycle; vector settling may be skipped.
  localparam logic [3:0] POWER_LAST =
    4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [3:0] WAIT_LAST  =
    4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam tester_state_e VEC_ENTRY =
    (SETTLE_CYCLES == 0) ? ST_CHECK : ST_WAIT;

  tester_state_e     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [8:0]        err_q, err_d;
  logic              fv_q, fv_d;
  logic [VEC_W-1:0]  fvec_q, fvec_d;

  logic [OUT_W-1:0]  exp_out;
  logic              mismatch;
  logic              accept_start;

  nor4_expect u_expect (
    .vec_i (vec_q),
    .exp_o (exp_out)
  );

  // Case inequality so an undriven or unknown output pin is flagged as a failure.
  assign mismatch     = (pins.dut_out !== exp_out);
  assign accept_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_POWER;
      ST_POWER:         if (cnt_q == POWER_LAST) state_d = VEC_ENTRY;
      ST_WAIT:          if (cnt_q == WAIT_LAST) state_d = ST_CHECK;
      ST_CHECK: begin
        if ((vec_q == '1) || (STOP_ON_FAIL && mismatch)) state_d = ST_DONE;
        else                                              state_d = VEC_ENTRY;
      end
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    pass          = 1'b0;
    pins.dut_vcc  = 1'b0;
    pins.dut_gnd  = 1'b0;
    pins.dut_in   = '0;
    case (state_q)
      ST_POWER, ST_WAIT, ST_CHECK: begin
        busy         = 1'b1;
        pins.dut_vcc = 1'b1;
        pins.dut_in  = vec_q;
      end
      ST_DONE: begin
        done = 1'b1;
        pass = (err_q == '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
    vec_d  = vec_q;
    err_d  = err_q;
    fv_d   = fv_q;
    fvec_d = fvec_q;
    if ((state_q == ST_IDLE) || (state_q == ST_DONE)) cnt_d = '0;
    if (accept_start) begin
      vec_d  = '0;
      err_d  = '0;
      fv_d   = 1'b0;
      fvec_d = '0;
    end else if (state_q == ST_CHECK) begin
      if (mismatch) begin
        err_d = err_q + 9'd1;
        if (!fv_q) begin
          fv_d   = 1'b1;
          fvec_d = vec_q;
        end
      end
      if (state_d != ST_DONE) vec_d = vec_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      vec_q  <= '0;
      err_q  <= '0;
      fv_q   <= 1'b0;
      fvec_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      vec_q  <= vec_d;
      err_q  <= err_d;
      fv_q   <= fv_d;
      fvec_q <= fvec_d;
    end
  end

  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_sn7402_tester.sv
// Directed bench for sn7402_tester against good and faulty SN7402 pin models.
module tb_sn7402_tester;
  import ttl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start0 = 1'b0;
  int   mode = 0;
  int   total = 0;
  int   bad = 0;
  int   cyc;

  always #5 clk = ~clk;

  sn7402_tester_if pins ();
  sn7402_tester_if pins0 ();

  logic       busy, done, pass, fvld;
  logic [8:0] errc;
  logic [7:0] fvec;
  logic       busy0, done0, pass0, fvld0;
  logic [8:0] errc0;
  logic [7:0] fvec0;

  // Device model: 0 good, 1 P10 stuck-at-0, 2 P1/P4 swapped
  function automatic logic [3:0] part(input logic [7:0] v, input logic vcc, input int m);
    logic [3:0] o;
    o = 4'b0000;
    if (vcc) begin
      for (int g = 0; g < 4; g++) o[g] = !(v[2*g] || v[2*g+1]);
      if (m == 1)      o[2] = 1'b0;
      else if (m == 2) o = {o[3:2], o[0], o[1]};
    end
    return o;
  endfunction

  assign pins.dut_out  = part(pins.dut_in, pins.dut_vcc, mode);
  assign pins0.dut_out = part(pins0.dut_in, pins0.dut_vcc, 0);

  sn7402_tester #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pins(pins),
    .busy(busy), .done(done), .pass(pass), .err_count(errc),
    .fail_valid(fvld), .fail_vec(fvec)
  );

  sn7402_tester #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .pins(pins0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(errc0),
    .fail_valid(fvld0), .fail_vec(fvec0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int pa, input int pb, output int n);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    chk("busy_after_start", busy, 1);
    chk("vcc_on", pins.dut_vcc, 1);
    chk("gnd_low", pins.dut_gnd, 0);
    chk("in_power_zero", pins.dut_in, 0);
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      start = (n == pa) || (n == pb);
      if (n == 17) chk("vec5_applied", pins.dut_in, 5);
    end
    start = 1'b0;
    chk("off_vcc", pins.dut_vcc, 0);
    chk("off_in", pins.dut_in, 0);
    chk("off_busy", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", errc, 0);
    chk("rst_fvld", fvld, 0);
    chk("rst_fvec", fvec, 0);
    chk("rst_vcc", pins.dut_vcc, 0);
    chk("rst_in", pins.dut_in, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1 good device
    mode = 0;
    run(-1, -1, cyc);
    chk("t1_cycles", cyc, 770);
    chk("t1_pass", pass, 1);
    chk("t1_err", errc, 0);
    chk("t1_fvld", fvld, 0);
    repeat (5) @(negedge clk);
    chk("t1_done_held", done, 1);

    // T2 P10 stuck-at-0
    mode = 1;
    run(-1, -1, cyc);
`ifdef SN7402_TESTER_STOP_ON_FAIL_EN
    chk("t2_cycles", cyc, 5);
    chk("t2_err", errc, 1);
`else
    chk("t2_cycles", cyc, 770);
    chk("t2_err", errc, 64);
`endif
    chk("t2_fvld", fvld, 1);
    chk("t2_fvec", fvec, 8'h00);
    chk("t2_pass", pass, 0);

    // T3 P1/P4 swapped: outputs differ on 6 of every 16 low-nibble patterns
    mode = 2;
    run(-1, -1, cyc);
`ifdef SN7402_TESTER_STOP_ON_FAIL_EN
    chk("t3_cycles", cyc, 8);
    chk("t3_err", errc, 1);
`else
    chk("t3_cycles", cyc, 770);
    chk("t3_err", errc, 96);
`endif
    chk("t3_fvec", fvec, 8'h01);
    chk("t3_pass", pass, 0);

    // T4 reset mid-run
`ifdef SN7402_TESTER_STOP_ON_FAIL_EN
    mode = 0;
`else
    mode = 1;
`endif
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (299) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_vcc", pins.dut_vcc, 0);
    chk("t4_in", pins.dut_in, 0);
    chk("t4_err", errc, 0);
    chk("t4_fvld", fvld, 0);
    chk("t4_fvec", fvec, 0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("t4_start_in_reset", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mode = 0;
    run(-1, -1, cyc);
    chk("t4_cycles", cyc, 770);
    chk("t4_pass", pass, 1);

    // T5 start pulses during a run
    run(5, 400, cyc);
    chk("t5_cycles", cyc, 770);
    chk("t5_pass", pass, 1);
    chk("t5_err", errc, 0);

    // T6 zero settle time, good device
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    cyc = 0;
    chk("t6_busy", busy0, 1);
    while (!done0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_cycles", cyc, 257);
    chk("t6_pass", pass0, 1);
    chk("t6_err", errc0, 0);
    chk("t6_fvld", fvld0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
